// File: rtl/inst_word_encoder_if.sv
// inst_word_encoder_if: field-bundle beat channel (valid/ready plus RV32I fields) feeding the encoder.
interface inst_word_encoder_if;
    logic        valid;
    logic        ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        last;
    modport master (output valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last, input ready);
    modport slave  (input valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last, output ready);
endinterface

// File: rtl/inst_word_encoder.sv
// inst_word_encoder: packs RV32I field bundles into words and streams them to IMEM at consecutive addresses.
// Define INST_ENC_CHECK_EN to reject immediates that do not fit their format.
module inst_word_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    inst_word_encoder_if.slave   bus,
    output logic                 imem_we_o,
    output logic [ADDR_W-1:0]    imem_addr_o,
    output logic [31:0]          imem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [ADDR_W:0]      count_o
);
    typedef enum logic [2:0] {IDLE, RUN, FLUSH, FULL, DONE} state_t;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d, done_q, done_d, err_q, err_d;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              legal, chk_ok, accept;
    logic [31:0]       imm;
    assign imm = bus.imm;
`ifdef INST_ENC_CHECK_EN
    logic s12, s13, s21;
    assign s12 = &imm[31:11] | ~|imm[31:11];
    assign s13 = &imm[31:12] | ~|imm[31:12];
    assign s21 = &imm[31:20] | ~|imm[31:20];
    assign chk_ok = (bus.fmt == 3'd1 || bus.fmt == 3'd2) ? s12 :
                    bus.fmt == 3'd3 ? s13 & ~imm[0] :
                    bus.fmt == 3'd4 ? ~|imm[11:0] :
                    bus.fmt == 3'd5 ? s21 & ~imm[0] : 1'b1;
`else
    logic unused_imm0;
    assign unused_imm0 = imm[0];
    assign chk_ok = 1'b1;
`endif
    always_comb begin
        word = '0;
        case (bus.fmt)
            3'd0: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd2: word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
            3'd3: word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], bus.opcode};
            3'd4: word = {imm[31:12], bus.rd, bus.opcode};
            3'd5: word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
            default: word = '0;
        endcase
    end
    assign legal     = (bus.fmt < 3'd6) && chk_ok;
    // The in-flight write counts against capacity so the last slot is never overbooked.
    assign bus.ready = (state_q == RUN) && ((count_q + (ADDR_W+1)'(we_q)) < DEPTH);
    assign accept    = bus.valid && bus.ready;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q + ADDR_W'(we_q);
        count_d = count_q + (ADDR_W+1)'(we_q);
        we_d    = accept && legal;
        wdata_d = we_d ? word : wdata_q;
        done_d  = 1'b0;
        err_d   = err_q || (accept && !legal);
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d = RUN;
                addr_d  = ADDR_W'(BASE_ADDR);
                count_d = '0;
                err_d   = 1'b0;
            end
            RUN: if (accept && bus.last) state_d = FLUSH;
                 else if (count_d == DEPTH) begin
                     state_d = FULL;
                     err_d   = 1'b1;
                 end
            FLUSH, FULL: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= ADDR_W'(BASE_ADDR);
            count_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q == RUN) || (state_q == FLUSH) || (state_q == FULL);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign count_o      = count_q;
endmodule

// File: tb/tb_inst_word_encoder.sv
// tb_inst_word_encoder: directed and randomized programs checked against an arithmetic field-packing model.
module tb_inst_word_encoder;
    localparam int AW = 2;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic          we, busy, done, err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [AW:0]   count;
    int            errors = 0, checks = 0;
    int            exp_addr[$];
    logic [31:0]   exp_data[$];
    int            m_addr = 0, m_cnt = 0;
    bit            m_err = 0;
    bit            acc;
    inst_word_encoder_if bus();
    inst_word_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
        .imem_we_o(we), .imem_addr_o(addr), .imem_wdata_o(wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .count_o(count)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic bit in_range(input int v, input int bits);
        return v >= -(1 << (bits - 1)) && v < (1 << (bits - 1));
    endfunction
    function automatic bit model_legal(input int fmt, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        if (fmt > 5) return 0;
`ifdef INST_ENC_CHECK_EN
        case (fmt)
            1, 2: return in_range(v, 12);
            3:    return in_range(v, 13) && (v % 2 == 0);
            4:    return (imm % 4096) == 0;
            5:    return in_range(v, 21) && (v % 2 == 0);
            default: return 1;
        endcase
`else
        return 1;
`endif
    endfunction
    function automatic logic [31:0] model_word(input int fmt, op, rd, rs1, rs2, f3, f7, input logic [31:0] im);
        logic [31:0] b;
        b = op | (f3 << 12) | (rs1 << 15);
        case (fmt)
            0: return b | (rd << 7) | (rs2 << 20) | (f7 << 25);
            1: return b | (rd << 7) | ((im % 4096) << 20);
            2: return b | ((im % 32) << 7) | (rs2 << 20) | (((im / 32) % 128) << 25);
            3: return b | (((im / 2048) % 2) << 7) | (((im / 2) % 16) << 8) | (rs2 << 20)
                        | (((im / 32) % 64) << 25) | (((im / 4096) % 2) << 31);
            4: return ((im / 4096) * 4096) | (rd << 7) | op;
            default: return op | (rd << 7) | (((im / 4096) % 256) << 12) | (((im / 2048) % 2) << 20)
                        | (((im / 2) % 1024) << 21) | (((im / 1048576) % 2) << 31);
        endcase
    endfunction
    always @(negedge clk) begin
        if (we) begin
            if (exp_addr.size() == 0) chk("spurious_write", 1, 0);
            else begin
                chk("wr_addr", addr, exp_addr.pop_front());
                chk("wr_data", wdata, exp_data.pop_front());
            end
        end
    end
    task automatic send(input int fmt, op, rd, rs1, rs2, f3, f7, input logic [31:0] imm, input bit last, output bit ok);
        bus.fmt = 3'(fmt); bus.opcode = 7'(op); bus.rd = 5'(rd); bus.rs1 = 5'(rs1); bus.rs2 = 5'(rs2);
        bus.funct3 = 3'(f3); bus.funct7 = 7'(f7); bus.imm = imm; bus.last = last; bus.valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 12 && !bus.ready; n++) begin @(posedge clk); #1; end
        if (bus.ready) begin
            @(posedge clk);
            ok = 1;
            if (model_legal(fmt, imm)) begin
                exp_addr.push_back(m_addr);
                exp_data.push_back(model_word(fmt, op, rd, rs1, rs2, f3, f7, imm));
                m_addr = (m_addr + 1) % (1 << AW);
                m_cnt++;
            end else m_err = 1;
            #1;
        end
        bus.valid = 1'b0;
    endtask
    task automatic start_prog();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_addr = 0; m_cnt = 0; m_err = 0;
        chk("busy_after_start", busy, 1);
        chk("count_after_start", count, 0);
        chk("err_cleared", err, 0);
    endtask
    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = done; end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("final_count", count, m_cnt);
        chk("final_err", err, m_err);
        chk("final_busy", busy, 0);
        chk("queue_drained", exp_addr.size(), 0);
        @(posedge clk); #1;
    endtask
    function automatic logic [31:0] rand_imm(input int fmt);
        int v;
        if ($urandom_range(0, 3) == 0) return $urandom;
        case (fmt)
            1, 2: v = int'($urandom_range(0, 4095)) - 2048;
            3:    v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            4:    return $urandom & 32'hFFFFF000;
            5:    v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
            default: return $urandom;
        endcase
        return v;
    endfunction
    initial begin
        int len, fmt;
        bus.valid = 0; bus.fmt = 0; bus.opcode = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0;
        bus.funct3 = 0; bus.funct7 = 0; bus.imm = 0; bus.last = 0;
        #12;
        chk("rst_we", we, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_count", count, 0); chk("rst_addr", addr, 0); chk("rst_ready", bus.ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        // single I-type, write visible the cycle after accept
        start_prog();
        send(1, 'h13, 1, 0, 0, 0, 0, 5, 1, acc);
        chk("i_accept", acc, 1); chk("i_we", we, 1); chk("i_addr", addr, 0); chk("i_wdata", wdata, 32'h00500093);
        wait_done();
        // back-to-back R then S
        start_prog();
        send(0, 'h33, 3, 1, 2, 0, 0, 0, 0, acc);
        chk("r_accept", acc, 1);
        send(2, 'h23, 0, 1, 2, 2, 0, 8, 1, acc);
        chk("s_accept", acc, 1); chk("s_we", we, 1); chk("s_addr", addr, 1); chk("s_wdata", wdata, 32'h0020A423);
        wait_done();
        // B, U, J with last
        start_prog();
        send(3, 'h63, 0, 1, 2, 0, 0, 8, 0, acc);
        send(4, 'h37, 5, 0, 0, 0, 0, 32'h12345000, 0, acc);
        send(5, 'h6F, 1, 0, 0, 0, 0, 32'h800, 1, acc);
        chk("j_wdata", wdata, 32'h001000EF);
        wait_done();
        chk("buj_count", count, 3);
        // overflow: DEPTH words without last
        start_prog();
        for (int i = 0; i < 4; i++) begin
            send(1, 'h13, i + 1, i, 0, 0, 0, i, 0, acc);
            chk("full_accept", acc, 1);
        end
        chk("full_ready_low", bus.ready, 0);
        send(1, 'h13, 7, 0, 0, 0, 0, 0, 0, acc);
        chk("fifth_rejected", acc, 0);
        chk("full_err", err, 1); chk("full_count", count, 4); chk("full_busy", busy, 0);
        chk("full_queue", exp_addr.size(), 0);
        // illegal fmt then misaligned B
        start_prog();
        send(7, 'h13, 1, 0, 0, 0, 0, 0, 0, acc);
        chk("ill_accept", acc, 1); chk("ill_no_we", we, 0); chk("ill_err", err, 1);
        send(3, 'h63, 0, 1, 2, 0, 0, 3, 1, acc);
        wait_done();
        // asynchronous reset while a write is pending
        start_prog();
        send(1, 'h13, 2, 0, 0, 0, 0, 9, 0, acc);
        chk("pre_rst_we", we, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", we, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_count", count, 0); chk("rst_mid_err", err, 0);
        exp_addr.delete(); exp_data.delete();
        @(posedge clk); #1; rst = 1'b0;
        start_prog();
        send(1, 'h13, 4, 0, 0, 0, 0, 6, 1, acc);
        chk("restart_addr", addr, 0);
        wait_done();
        // random programs
        for (int p = 0; p < 20; p++) begin
            start_prog();
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                fmt = ($urandom_range(0, 99) < 10) ? 6 + $urandom_range(0, 1) : $urandom_range(0, 5);
                send(fmt, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 7), $urandom_range(0, 127), rand_imm(fmt), b == len - 1, acc);
                chk("rand_accept", acc, 1);
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            wait_done();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
